// File: rtl/assoc_wb_cache.sv
// assoc_wb_cache
//   Set-associative, write-back, write-allocate cache with byte write enables,
//   true-LRU replacement and a whole-cache flush. It sits between the CPU
//   load/store port and a single-port word SRAM with a one-cycle read latency.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   address           CPU byte address, held stable until data_ready
//   data_in_cpu, wr   write data and byte enables (wr != 0 means write)
//   rd                read request (level)
//   flush             write back every dirty line, then invalidate everything
//   hit_miss          1 = request hit at lookup (valid with data_ready)
//   data2cpu          read data / post-merge write word (valid with data_ready)
//   data_ready        one-cycle completion pulse
//   data2mem, m_wr_address, mwren   write-back port, one word per cycle
//   m_rd_address, mrden, data_in_mem fill port, data arrives the cycle after mrden
module assoc_wb_cache #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int WAYS       = 2,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic                 clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   data_in_cpu,
  input  logic                rd,
  input  logic [DATA_W/8-1:0] wr,
  input  logic                flush,
  output logic                hit_miss,
  output logic [DATA_W-1:0]   data2cpu,
  output logic                data_ready,
  output logic [DATA_W-1:0]   data2mem,
  output logic [ADDR_W-1:0]   m_rd_address,
  output logic [ADDR_W-1:0]   m_wr_address,
  output logic                mrden,
  output logic                mwren,
  input  logic [DATA_W-1:0]   data_in_mem
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int WRD_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - OFF_W - WRD_W - IDX_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int CNT_W = WRD_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WB, S_FILL, S_RESP, S_FLUSH
  } state_t;

  typedef struct packed {
    logic              is_wr;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] din;
    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  idx;
    logic [WRD_W-1:0]  wrd;
  } req_t;

  typedef logic [WAYS-1:0][WAY_W-1:0] age_row_t;

  // Storage. Data and tags carry no reset; valid/dirty/age do.
  logic [DATA_W-1:0] data_arr [SETS][WAYS][LINE_WORDS];
  logic [TAG_W-1:0]  tag_arr  [SETS][WAYS];
  logic [SETS-1:0][WAYS-1:0]            valid, dirty;
  logic [SETS-1:0][WAYS-1:0][WAY_W-1:0] age;   // 0 = MRU, WAYS-1 = LRU

  state_t            state;
  req_t              req;
  logic [WAY_W-1:0]  way_q;
  logic              hit_q, fl_q, rd_q;
  logic [CNT_W-1:0]  cnt;                      // words issued (WB or FILL)
  logic [WRD_W-1:0]  cap;                      // words captured in FILL
  logic [IDX_W-1:0]  f_set;
  logic [WAY_W-1:0]  f_way;
  logic [WRD_W-1:0]  f_cnt;
  logic              f_done;

  logic              unused_bits;
  assign unused_bits = ^address[OFF_W-1:0];

  // Ages form a permutation per set; touching way w makes it 0 and ages
  // every way that was younger than it, so the order stays a permutation.
  function automatic age_row_t lru_touch(input age_row_t row, input logic [WAY_W-1:0] w);
    lru_touch = row;
    for (int v = 0; v < WAYS; v++) begin
      if (WAY_W'(v) == w)     lru_touch[v] = '0;
      else if (row[v] < row[w]) lru_touch[v] = row[v] + 1'b1;
    end
  endfunction

  // Tag compare, one comparator per way
  logic [WAYS-1:0] way_hit;
  for (genvar w = 0; w < WAYS; w++) begin : g_cmp
    assign way_hit[w] = valid[req.idx][w] && (tag_arr[req.idx][w] == req.tag);
  end

  logic             hit, vfound, vict_dirty;
  logic [WAY_W-1:0] hit_way, vict;
  assign hit = |way_hit;

  always_comb begin
    hit_way = '0;
    vict    = '0;
    vfound  = 1'b0;
    for (int w = 0; w < WAYS; w++)
      if (way_hit[w]) hit_way = WAY_W'(w);
    // descending scan so the lowest-numbered invalid way wins
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid[req.idx][w]) begin
        vict   = WAY_W'(w);
        vfound = 1'b1;
      end
    if (!vfound)
      for (int w = 0; w < WAYS; w++)
        if (age[req.idx][w] == WAY_W'(WAYS - 1)) vict = WAY_W'(w);
  end
  assign vict_dirty = valid[req.idx][vict] && dirty[req.idx][vict];

  // Byte merge of the requested word; with be == 0 this is the stored word.
  logic [DATA_W-1:0] old_word, merged;
  assign old_word = data_arr[req.idx][way_q][req.wrd];
  always_comb begin
    merged = old_word;
    for (int b = 0; b < BE_W; b++)
      if (req.be[b]) merged[8*b +: 8] = req.din[8*b +: 8];
  end

  logic fill_we, fill_last, resp_we;
  assign fill_we   = (state == S_FILL) && rd_q;
  assign fill_last = fill_we && (cap == WRD_W'(LINE_WORDS - 1));
  assign resp_we   = (state == S_RESP) && req.is_wr && !fl_q;

  always_ff @(posedge clk) begin
    if (fill_we)   data_arr[req.idx][way_q][cap] <= data_in_mem;
    if (fill_last) tag_arr[req.idx][way_q]       <= req.tag;
    if (resp_we)   data_arr[req.idx][way_q][req.wrd] <= merged;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      req          <= '0;
      way_q        <= '0;
      hit_q        <= 1'b0;
      fl_q         <= 1'b0;
      rd_q         <= 1'b0;
      cnt          <= '0;
      cap          <= '0;
      f_set        <= '0;
      f_way        <= '0;
      f_cnt        <= '0;
      f_done       <= 1'b0;
      valid        <= '0;
      dirty        <= '0;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age[s][w] <= WAY_W'(w);
      hit_miss     <= 1'b0;
      data2cpu     <= '0;
      data_ready   <= 1'b0;
      data2mem     <= '0;
      m_rd_address <= '0;
      m_wr_address <= '0;
      mrden        <= 1'b0;
      mwren        <= 1'b0;
    end else begin
      rd_q <= mrden;   // data for a strobe is on data_in_mem one cycle later
      case (state)
        S_IDLE: begin
          data_ready <= 1'b0;
          hit_miss   <= 1'b0;
          data2cpu   <= '0;
          // The cycle after data_ready the CPU may still hold its request;
          // skip it so the same request is not taken twice.
          if (!data_ready) begin
            if (rd || wr != '0) begin
              req.is_wr <= (wr != '0);
              req.be    <= wr;
              req.din   <= data_in_cpu;
              req.tag   <= address[ADDR_W-1 -: TAG_W];
              req.idx   <= address[OFF_W+WRD_W +: IDX_W];
              req.wrd   <= address[OFF_W +: WRD_W];
              state     <= S_LOOKUP;
            end else if (flush) begin
              f_set  <= '0;
              f_way  <= '0;
              f_cnt  <= '0;
              f_done <= 1'b0;
              state  <= S_FLUSH;
            end
          end
        end

        S_LOOKUP: begin
          hit_q <= hit;
          cap   <= '0;
          cnt   <= CNT_W'(1);
          if (hit) begin
            way_q          <= hit_way;
            age[req.idx]   <= lru_touch(age[req.idx], hit_way);
            state          <= S_RESP;
          end else begin
            way_q <= vict;
            // first word of the burst goes out on this edge
            if (vict_dirty) begin
              mwren        <= 1'b1;
              m_wr_address <= {tag_arr[req.idx][vict], req.idx, {WRD_W{1'b0}}, {OFF_W{1'b0}}};
              data2mem     <= data_arr[req.idx][vict][0];
              state        <= S_WB;
            end else begin
              mrden        <= 1'b1;
              m_rd_address <= {req.tag, req.idx, {WRD_W{1'b0}}, {OFF_W{1'b0}}};
              state        <= S_FILL;
            end
          end
        end

        S_WB: begin
          if (cnt == CNT_W'(LINE_WORDS)) begin
            mwren        <= 1'b0;
            mrden        <= 1'b1;
            m_rd_address <= {req.tag, req.idx, {WRD_W{1'b0}}, {OFF_W{1'b0}}};
            cnt          <= CNT_W'(1);
            cap          <= '0;
            state        <= S_FILL;
          end else begin
            m_wr_address <= {tag_arr[req.idx][way_q], req.idx, cnt[WRD_W-1:0], {OFF_W{1'b0}}};
            data2mem     <= data_arr[req.idx][way_q][cnt[WRD_W-1:0]];
            cnt          <= cnt + 1'b1;
          end
        end

        S_FILL: begin
          if (cnt != CNT_W'(LINE_WORDS)) begin
            mrden        <= 1'b1;
            m_rd_address <= {req.tag, req.idx, cnt[WRD_W-1:0], {OFF_W{1'b0}}};
            cnt          <= cnt + 1'b1;
          end else begin
            mrden <= 1'b0;
          end
          if (rd_q) cap <= cap + 1'b1;
          if (fill_last) begin
            valid[req.idx][way_q] <= 1'b1;
            dirty[req.idx][way_q] <= 1'b0;
            age[req.idx]          <= lru_touch(age[req.idx], way_q);
            state                 <= S_RESP;
          end
        end

        S_RESP: begin
          data_ready <= 1'b1;
          if (fl_q) begin
            hit_miss <= 1'b0;
            data2cpu <= '0;
          end else begin
            hit_miss <= hit_q;
            data2cpu <= merged;
            if (req.is_wr) dirty[req.idx][way_q] <= 1'b1;
          end
          fl_q  <= 1'b0;
          state <= S_IDLE;
        end

        S_FLUSH: begin
          if (f_done) begin
            mwren <= 1'b0;
            valid <= '0;
            dirty <= '0;
            hit_q <= 1'b0;
            fl_q  <= 1'b1;
            state <= S_RESP;
          end else begin
            if (valid[f_set][f_way] && dirty[f_set][f_way]) begin
              mwren        <= 1'b1;
              m_wr_address <= {tag_arr[f_set][f_way], f_set, f_cnt, {OFF_W{1'b0}}};
              data2mem     <= data_arr[f_set][f_way][f_cnt];
              f_cnt        <= f_cnt + 1'b1;
            end else begin
              mwren <= 1'b0;
            end
            // move on after a clean line or the last word of a dirty one
            if (!(valid[f_set][f_way] && dirty[f_set][f_way]) ||
                f_cnt == WRD_W'(LINE_WORDS - 1)) begin
              f_cnt <= '0;
              if (f_way == WAY_W'(WAYS - 1)) begin
                f_way <= '0;
                if (f_set == IDX_W'(SETS - 1)) f_done <= 1'b1;
                else                           f_set  <= f_set + 1'b1;
              end else begin
                f_way <= f_way + 1'b1;
              end
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_assoc_wb_cache.sv
// tb_assoc_wb_cache
//   Directed bench for assoc_wb_cache (WAYS=2, SETS=64, LINE_WORDS=4) against
//   a word memory with one-cycle read latency. Every memory strobe is logged
//   as {is_write, address} so burst order and addresses can be checked.
module tb_assoc_wb_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] address;
  logic [31:0] data_in_cpu;
  logic        rd;
  logic [3:0]  wr;
  logic        flush;
  logic        hit_miss;
  logic [31:0] data2cpu;
  logic        data_ready;
  logic [31:0] data2mem;
  logic [15:0] m_rd_address;
  logic [15:0] m_wr_address;
  logic        mrden;
  logic        mwren;
  logic [31:0] data_in_mem;

  assoc_wb_cache #(
    .ADDR_W(16), .DATA_W(32), .WAYS(2), .SETS(64), .LINE_WORDS(4)
  ) dut (
    .clk(clk), .rst(rst), .address(address), .data_in_cpu(data_in_cpu),
    .rd(rd), .wr(wr), .flush(flush), .hit_miss(hit_miss), .data2cpu(data2cpu),
    .data_ready(data_ready), .data2mem(data2mem), .m_rd_address(m_rd_address),
    .m_wr_address(m_wr_address), .mrden(mrden), .mwren(mwren),
    .data_in_mem(data_in_mem)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [16384];
  logic [16:0] ev_q [$];
  int          both_cnt = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  always @(posedge clk) begin
    if (mrden) begin
      data_in_mem <= mem[m_rd_address[15:2]];
      ev_q.push_back({1'b0, m_rd_address});
    end
    if (mwren) begin
      mem[m_wr_address[15:2]] <= data2mem;
      ev_q.push_back({1'b1, m_wr_address});
    end
    if (mrden && mwren) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // four logged strobes starting at idx: same kind, ascending word addresses
  task automatic chk_burst(input string tag, input int idx, input logic is_wr, input logic [15:0] a0);
    for (int k = 0; k < 4; k++) begin
      if (idx + k < ev_q.size())
        chk(tag, {15'b0, ev_q[idx+k]}, {15'b0, is_wr, a0 + 16'(4*k)});
      else
        chk({tag, "_missing"}, 32'(idx + k), 32'(ev_q.size()));
    end
  endtask

  // Issue one request; lat = edges from the sampling edge to data_ready.
  task automatic do_req(input logic [15:0] a, input logic [31:0] d, input logic r,
                        input logic [3:0] be, output logic hm, output logic [31:0] q,
                        output int lat);
    @(negedge clk);
    address = a; data_in_cpu = d; rd = r; wr = be;
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (data_ready) begin
        lat = n - 1;
        break;
      end
    end
    hm = hit_miss;
    q  = data2cpu;
    rd = 1'b0; wr = 4'b0;
    if (lat < 0) chk("req_timeout", 32'(lat), 32'd0);
  endtask

  logic        hm;
  logic [31:0] q;
  int          lat, b, pulses, seen;

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'hA500_0000 | 32'(i);
    mem[16'h0000 >> 2] = 32'hAABB_CCDD;
    mem[16'h0404 >> 2] = 32'h1234_5678;
    data_in_mem = '0;
    rst = 1'b0; rd = 1'b0; wr = 4'b0; flush = 1'b0; address = '0; data_in_cpu = '0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {27'b0, data_ready, hit_miss, mrden, mwren, 1'b0}, 32'd0);
    chk("rst_data2cpu", data2cpu, 32'd0);
    chk("rst_data2mem", data2mem, 32'd0);
    chk("rst_maddr", {m_rd_address, m_wr_address}, 32'd0);
    @(negedge clk); rst = 1'b1;

    // T1: cold miss then hit
    b = ev_q.size();
    do_req(16'h0404, 32'h0, 1'b1, 4'b0, hm, q, lat);
    chk("t1_miss", 32'(hm), 32'd0);
    chk("t1_data", q, 32'h1234_5678);
    chk("t1_lat", 32'(lat), 32'd7);
    chk("t1_nev", 32'(ev_q.size() - b), 32'd4);
    chk_burst("t1_fill", b, 1'b0, 16'h0400);
    @(negedge clk);
    chk("t1_ready_drop", {30'b0, data_ready, hit_miss}, 32'd0);
    chk("t1_data_drop", data2cpu, 32'd0);
    do_req(16'h0404, 32'h0, 1'b1, 4'b0, hm, q, lat);
    chk("t1_hit", 32'(hm), 32'd1);
    chk("t1_hit_data", q, 32'h1234_5678);
    chk("t1_hit_lat", 32'(lat), 32'd2);

    // T2: LRU eviction in set 0
    do_req(16'h1404, 32'h0, 1'b1, 4'b0, hm, q, lat);
    chk("t2_a_miss", 32'(hm), 32'd0);
    chk("t2_a_data", q, 32'hA500_0501);
    do_req(16'h0404, 32'h0, 1'b1, 4'b0, hm, q, lat);
    chk("t2_b_hit", 32'(hm), 32'd1);
    do_req(16'h2404, 32'h0, 1'b1, 4'b0, hm, q, lat);
    chk("t2_c_miss", 32'(hm), 32'd0);
    chk("t2_c_data", q, 32'hA500_0901);
    do_req(16'h0404, 32'h0, 1'b1, 4'b0, hm, q, lat);
    chk("t2_d_hit", 32'(hm), 32'd1);
    do_req(16'h1404, 32'h0, 1'b1, 4'b0, hm, q, lat);
    chk("t2_e_miss", 32'(hm), 32'd0);
    chk("t2_e_lat", 32'(lat), 32'd7);

    // T3: write-allocate with byte merge, no write-back yet
    b = ev_q.size();
    do_req(16'h0000, 32'h1111_1111, 1'b0, 4'b0011, hm, q, lat);
    chk("t3_wr_miss", 32'(hm), 32'd0);
    chk("t3_wr_data", q, 32'hAABB_1111);
    chk("t3_wr_lat", 32'(lat), 32'd7);
    do_req(16'h0000, 32'h0, 1'b1, 4'b0, hm, q, lat);
    chk("t3_rd_hit", 32'(hm), 32'd1);
    chk("t3_rd_data", q, 32'hAABB_1111);
    seen = 0;
    for (int i = b; i < ev_q.size(); i++) if (ev_q[i][16]) seen++;
    chk("t3_no_mwren", 32'(seen), 32'd0);

    // T4: dirty victim written back before the fill
    do_req(16'h1000, 32'h0, 1'b1, 4'b0, hm, q, lat);
    chk("t4_a_data", q, 32'hA500_0400);
    b = ev_q.size();
    do_req(16'h2000, 32'h0, 1'b1, 4'b0, hm, q, lat);
    chk("t4_b_miss", 32'(hm), 32'd0);
    chk("t4_b_data", q, 32'hA500_0800);
    chk("t4_b_lat", 32'(lat), 32'd11);
    chk("t4_nev", 32'(ev_q.size() - b), 32'd8);
    chk_burst("t4_wb", b, 1'b1, 16'h0000);
    chk_burst("t4_fill", b + 4, 1'b0, 16'h2000);
    chk("t4_mem0", mem[0], 32'hAABB_1111);

    // T5: flush with dirty lines in sets 0 and 5
    do_req(16'h2000, 32'hDEAD_BEEF, 1'b0, 4'b1111, hm, q, lat);
    chk("t5_wr_hit", 32'(hm), 32'd1);
    chk("t5_wr_data", q, 32'hDEAD_BEEF);
    do_req(16'h0050, 32'h7700_0000, 1'b0, 4'b1000, hm, q, lat);
    chk("t5_wr5_data", q, 32'h7700_0014);
    b = ev_q.size();
    pulses = 0;
    hm = 1'b1;
    @(negedge clk); flush = 1'b1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (data_ready) begin
        pulses++;
        hm = hit_miss;
        flush = 1'b0;
        break;
      end
    end
    flush = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (data_ready) pulses++;
    end
    chk("t5_pulses", 32'(pulses), 32'd1);
    chk("t5_hit_miss", 32'(hm), 32'd0);
    chk("t5_nev", 32'(ev_q.size() - b), 32'd8);
    chk_burst("t5_wb_s0", b, 1'b1, 16'h2000);
    chk_burst("t5_wb_s5", b + 4, 1'b1, 16'h0050);
    chk("t5_mem_s0", mem[16'h2000 >> 2], 32'hDEAD_BEEF);
    chk("t5_mem_s5", mem[16'h0050 >> 2], 32'h7700_0014);
    do_req(16'h2000, 32'h0, 1'b1, 4'b0, hm, q, lat);
    chk("t5_post_s0_miss", 32'(hm), 32'd0);
    chk("t5_post_s0_data", q, 32'hDEAD_BEEF);
    do_req(16'h0050, 32'h0, 1'b1, 4'b0, hm, q, lat);
    chk("t5_post_s5_miss", 32'(hm), 32'd0);
    chk("t5_post_s5_data", q, 32'h7700_0014);

    // T6: reset in the middle of a fill
    @(negedge clk);
    address = 16'h0404; rd = 1'b1;
    seen = 0;
    for (int n = 0; n < 20 && seen < 2; n++) begin
      @(negedge clk);
      if (mrden) seen++;
    end
    chk("t6_reach_fill", 32'(seen), 32'd2);
    #1 rst = 1'b0;
    #1;
    chk("t6_async_ctrl", {28'b0, mrden, mwren, data_ready, hit_miss}, 32'd0);
    chk("t6_async_addr", {m_rd_address, m_wr_address}, 32'd0);
    rd = 1'b0;
    b = ev_q.size();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_quiet", 32'(ev_q.size() - b), 32'd0);
    b = ev_q.size();
    do_req(16'h0404, 32'h0, 1'b1, 4'b0, hm, q, lat);
    chk("t6_miss", 32'(hm), 32'd0);
    chk("t6_data", q, 32'h1234_5678);
    chk("t6_lat", 32'(lat), 32'd7);
    chk_burst("t6_fill", b, 1'b0, 16'h0400);

    chk("no_rd_wr_overlap", 32'(both_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
